mat_rd_arb: RTL
===============

# mat_rd_arb

Round-robin arbiter and sequencer for the single-port matrix storage read interface. It lets several operation units share one storage read port: mat_add, scalar/multiply units and the display scanner. Each unit issues one-element reads through an rd_en / rd_slot_idx / row / col request. The arbiter serialises the reads into single storage accesses and returns each element with a one-cycle per-requester valid pulse, matching the existing rd_elem / rd_elem_valid contract.

## Interface
- NUM_REQ, 3, number of requesters (2..4)
- DIM_WIDTH, 3, row/col index width
- DATA_WIDTH, 8, element width
- RD_LAT, 1, storage read latency in cycles (1..4)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_rd_en  in  NUM_REQ  per-requester read request level
- req_slot  in  NUM_REQ  per-requester slot index
- req_row  in  NUM_REQ*DIM_WIDTH  per-requester row; requester i occupies bits [i*DIM_WIDTH +: DIM_WIDTH]
- req_col  in  NUM_REQ*DIM_WIDTH  per-requester column; same packing as req_row
- rsp_elem  out  DATA_WIDTH  returned element, broadcast to all requesters
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the owning requester
- mem_rd_en  out  1  storage read strobe, one cycle per access
- mem_slot  out  1  storage slot address
- mem_row  out  DIM_WIDTH  storage row address
- mem_col  out  DIM_WIDTH  storage column address
- mem_rdata  in  DATA_WIDTH  storage data, valid RD_LAT cycles after mem_rd_en
- busy  out  1  a transaction is in flight (any state other than IDLE)
- grant_id  out  2  index of the current or last granted requester

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: drive the storage access.
  - WAIT: count RD_LAT cycles.
  - RESP: return the element.
- IDLE → ISSUE when any eligible req_rd_en is high. Otherwise stay in IDLE.
- Requester eligibility: req_rd_en[i] is high, and i is not masked.
- Round-robin pointer:
  - The search starts at (last grant + 1) mod NUM_REQ.
  - The pointer updates to the winner on each grant.
  - The reset pointer makes requester 0 first.
- On grant:
  - Latch the winner's slot/row/col into mem_* registers.
  - Set mem_rd_en = 1 for the ISSUE cycle only.
  - Update grant_id.
- ISSUE → WAIT. Load the latency counter with RD_LAT.
- WAIT: decrement the counter. On the last WAIT cycle, register mem_rdata into rsp_elem and set rsp_valid[grant_id]. WAIT → RESP.
- RESP: rsp_valid is high this cycle only. Then go to IDLE.
- rsp_elem holds its value after RESP; it is not cleared.
- Re-arm mask: the requester served in RESP is ineligible in the first IDLE cycle after RESP. This gives a requester one cycle to change its address (e.g. A-slot → B-slot) while holding rd_en high. Other requesters may win that cycle.
- Request inputs are sampled only in IDLE. Address changes in other states are ignored.
- Dropping rd_en after a grant does not abort the transaction. The response still pulses and the requester discards it.
- The storage port carries at most one transaction; there is no pipelining.
- Reset values:
  - mem_rd_en, rsp_valid, busy: 0.
  - mem_slot/row/col, rsp_elem: 0.
  - grant_id: NUM_REQ-1.
  - State: IDLE.
  - Mask: clear.
- Reset mid-transaction: abort immediately. No rsp_valid is emitted after reset release for the aborted read.

## Timing
- Definition: t0 is the IDLE cycle in which requester i is sampled and wins.
- Per-transaction cycle timing:
  - mem_rd_en is high at t0+1.
  - mem_rdata is captured at the end of t0+1+RD_LAT.
  - rsp_valid[i] is high at t0+RD_LAT+2.
  - The arbiter is back in IDLE at t0+RD_LAT+3.
- Minimum period per read: RD_LAT+3 cycles. This is 4 at the default, so one mat_add element (A + B) costs at least 8 cycles.
- All outputs are registered. There are no combinational input-to-output paths.
- Simultaneous requests in IDLE: the round-robin order decides the winner. Losers keep rd_en high and win in later IDLE cycles. The bound is NUM_REQ-1 intervening transactions.

## Structure
- Shared package mat_pkg holds:
  - the state encoding localparams (S_IDLE, S_ISSUE, S_WAIT, S_RESP);
  - DIM_WIDTH and DATA_WIDTH defaults;
  - the RD_LAT maximum.
- Natural sub-module: rr_pick. It is combinational, taking a request vector, mask and pointer and producing the winner index and a found flag. It is reused by a future write-port arbiter.

## Test plan
- Single requester, RD_LAT=1: req 0 asks for slot 1, row 2, col 3, with mem_rdata=0x5A. The arbiter must give mem_rd_en at t0+1 with address (1,2,3), and rsp_valid=3'b001 with rsp_elem=0x5A at t0+3.
- All three requesters high continuously from reset: grants must run 0,1,2,0,1,2 with one rsp_valid pulse each, 4 cycles apart.
- mat_add-style re-arm: req 0 holds rd_en and switches slot from 0 to 1 in the cycle after its rsp_valid. The second access must use slot 1, never a repeat of slot 0.
- RD_LAT=3: rsp_valid must appear at t0+5 and mem_rdata must be sampled exactly at t0+4. Driving 0xFF in other cycles must not corrupt rsp_elem.
- Requester drops rd_en during WAIT: rsp_valid still pulses once. The next IDLE cycle must not re-grant that requester.
- Assert rst_n low during WAIT: all outputs must return to their reset values asynchronously, and no rsp_valid may appear after release.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix storage port arbiters.
// Holds the arbiter state encoding, default index/data widths, the largest
// supported storage read latency and the widths derived from it.
package mat_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DIM_WIDTH_DEF  = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int RD_LAT_MAX     = 4;

  // Requester index width; covers up to four requesters.
  localparam int GID_WIDTH = 2;
  // Latency counter width; must hold RD_LAT_MAX.
  localparam int CNT_WIDTH = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    - request vector, one bit per requester
//   mask   - requesters excluded from this pick
//   ptr    - last granted index; the search starts at ptr+1 and wraps
//   winner - index of the first eligible requester found
//   found  - at least one requester is eligible
module rr_pick
  import mat_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [GID_WIDTH-1:0] ptr,
  output logic [GID_WIDTH-1:0] winner,
  output logic                 found
);

  logic [N-1:0]   elig;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  assign elig = req & ~mask;
  assign dbl  = {elig, elig};

  // Rotate so that bit 0 of rot is requester ptr+1; the lowest set bit of
  // rot is then the round-robin winner.
  always_comb begin
    rot    = N'(dbl >> (32'(ptr) + 32'd1));
    found  = 1'b0;
    winner = ptr;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found  = 1'b1;
        winner = GID_WIDTH'((32'(ptr) + 32'd1 + 32'(j)) % N);
      end
    end
  end

endmodule

// File: rtl/mat_rd_arb.sv
// Round-robin arbiter and sequencer for the single-port matrix storage read
// interface. Requesters raise req_rd_en with a slot/row/col address; each
// granted read is issued to storage as one mem_rd_en strobe and the element
// comes back on rsp_elem with a one-cycle pulse on the owner's rsp_valid bit.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_rd_en/slot/     - per-requester request level and address
//   req_row/req_col       (row/col packed DIM_WIDTH per requester)
//   rsp_elem, rsp_valid - returned element and one-hot owner pulse
//   mem_rd_en, mem_slot,
//   mem_row, mem_col    - storage read strobe and address
//   mem_rdata           - storage data, valid RD_LAT cycles after the strobe
//   busy                - a transaction is in flight
//   grant_id            - current or last granted requester
module mat_rd_arb
  import mat_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LAT     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_rd_en,
  input  logic [NUM_REQ-1:0]             req_slot,
  input  logic [NUM_REQ*DIM_WIDTH-1:0]   req_row,
  input  logic [NUM_REQ*DIM_WIDTH-1:0]   req_col,
  output logic [DATA_WIDTH-1:0]          rsp_elem,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           mem_rd_en,
  output logic                           mem_slot,
  output logic [DIM_WIDTH-1:0]           mem_row,
  output logic [DIM_WIDTH-1:0]           mem_col,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           busy,
  output logic [GID_WIDTH-1:0]           grant_id
);

  state_t                 state;
  state_t                 next_state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [NUM_REQ-1:0]     mask;
  logic [GID_WIDTH-1:0]   win;
  logic                   found;
  logic                   last_wait;

  // grant_id doubles as the round-robin pointer: it resets to NUM_REQ-1 so
  // the first search starts at requester 0.
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req_rd_en),
    .mask   (mask),
    .ptr    (grant_id),
    .winner (win),
    .found  (found)
  );

  assign last_wait = (state == S_WAIT) && (cnt == CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (found) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (cnt == CNT_WIDTH'(1)) next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en <= 1'b0;
      mem_slot  <= 1'b0;
      mem_row   <= '0;
      mem_col   <= '0;
      rsp_elem  <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
      grant_id  <= GID_WIDTH'(NUM_REQ - 1);
      cnt       <= '0;
      mask      <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      rsp_valid <= '0;
      busy      <= (next_state != S_IDLE);

      if (state == S_IDLE && found) begin
        grant_id  <= win;
        mem_slot  <= req_slot[win];
        mem_row   <= req_row[int'(win)*DIM_WIDTH +: DIM_WIDTH];
        mem_col   <= req_col[int'(win)*DIM_WIDTH +: DIM_WIDTH];
        mem_rd_en <= 1'b1;
      end

      if (state == S_ISSUE) cnt <= CNT_WIDTH'(RD_LAT);
      else if (state == S_WAIT) cnt <= cnt - 1'b1;

      if (last_wait) begin
        rsp_elem  <= mem_rdata;
        rsp_valid <= NUM_REQ'(1) << grant_id;
      end

      // The requester just served sits out exactly one IDLE cycle so it can
      // move to its next address while still holding rd_en.
      if (state == S_RESP)      mask <= NUM_REQ'(1) << grant_id;
      else if (state == S_IDLE) mask <= '0;
    end
  end

endmodule
